// File: rtl/dsm_dac_ctrl.sv
// dsm_dac_ctrl: sample-rate sequencer in front of a delta-sigma DAC modulator.
// A one-entry buffer takes signed PCM samples over a valid/ready stream. The
// block strobes the modulator clock-enable at clk/CLK_DIV and presents one
// sample for every OSR enables. Stop requests are honoured at the next sample
// boundary and are followed by FLUSH_PERIODS zero-valued periods. Periods that
// find the buffer empty are flagged as underruns.
//
// Optional build macro: DSM_DAC_CTRL_HOLD_ON_UNDERRUN_EN
//   defined   - on an underrun, o_dac_data holds its previous value
//   undefined - on an underrun, o_dac_data is forced to 0
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          level: 1 = run, 0 = request stop
//   i_s_valid/o_s_ready/i_s_data   sample stream (signed DATA_WIDTH)
//   o_dac_en         modulator clock-enable strobe (decoded from registers)
//   o_dac_data       sample presented to the modulator
//   o_sample_tick    pulse on the last enable of each sample period
//   o_busy           sequencer not idle
//   o_underrun       sticky underrun flag, cleared by i_clr_status
module dsm_dac_ctrl #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned OSR           = 64,
    parameter int unsigned CLK_DIV       = 1,
    parameter int unsigned FLUSH_PERIODS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_dac_en,
    output logic [DATA_WIDTH-1:0] o_dac_data,
    output logic                  o_sample_tick,
    output logic                  o_busy,
    output logic                  o_underrun,
    input  logic                  i_clr_status
);

    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OSR_W     = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int unsigned FL_W      = (FLUSH_PERIODS > 1) ? $clog2(FLUSH_PERIODS) : 1;
    localparam int unsigned DIV_LAST  = CLK_DIV - 1;
    localparam int unsigned OSR_LAST  = OSR - 1;
    localparam int unsigned FL_LAST   = (FLUSH_PERIODS > 0) ? FLUSH_PERIODS - 1 : 0;
    localparam bit          HAS_FLUSH = (FLUSH_PERIODS != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [OSR_W-1:0]        osr_cnt_q, osr_cnt_d;
    logic [FL_W-1:0]         flush_cnt_q, flush_cnt_d;
    logic                    stop_pend_q, stop_pend_d;
    logic [DATA_WIDTH-1:0]   dac_data_q, dac_data_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    underrun_q, underrun_d;
    logic                    underrun_set;

    logic                    running_c;
    logic                    dac_en_c;
    logic                    boundary_c;
    logic                    xfer_c;

    // Enable and boundary strobes are pure decodes of registered state.
    assign running_c  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign dac_en_c   = running_c && (div_cnt_q == DIV_W'(DIV_LAST));
    assign boundary_c = dac_en_c && (osr_cnt_q == OSR_W'(OSR_LAST));
    assign xfer_c     = i_s_valid && ready_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        div_cnt_d    = div_cnt_q;
        osr_cnt_d    = osr_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        stop_pend_d  = stop_pend_q;
        dac_data_d   = dac_data_q;
        underrun_set = 1'b0;

        // ready is only high while the buffer is empty, so a transfer never
        // collides with a buffer that still holds an unplayed sample.
        if (xfer_c) begin
            buf_d      = i_s_data;
            buf_full_d = 1'b1;
        end

        if (running_c) begin
            div_cnt_d = dac_en_c ? '0 : div_cnt_q + DIV_W'(1);
            if (dac_en_c) begin
                osr_cnt_d = boundary_c ? '0 : osr_cnt_q + OSR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WAIT_FIRST;
                end
            end

            ST_WAIT_FIRST: begin
                if (buf_full_q) begin
                    dac_data_d = buf_q;
                    buf_full_d = 1'b0;
                    div_cnt_d  = '0;
                    osr_cnt_d  = '0;
                    state_d    = ST_RUN;
                end else if (!i_start) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Once a stop is seen it stays pending until IDLE.
                if (!i_start) begin
                    stop_pend_d = 1'b1;
                end
                if (boundary_c) begin
                    if (stop_pend_q || !i_start) begin
                        dac_data_d  = '0;
                        flush_cnt_d = '0;
                        state_d     = HAS_FLUSH ? ST_FLUSH : ST_IDLE;
                    end else if (buf_full_q) begin
                        dac_data_d = buf_q;
                        buf_full_d = 1'b0;
                    end else begin
                        underrun_set = 1'b1;
`ifndef DSM_DAC_CTRL_HOLD_ON_UNDERRUN_EN
                        dac_data_d   = '0;
`endif
                    end
                end
            end

            ST_FLUSH: begin
                dac_data_d = '0;
                if (boundary_c) begin
                    if (flush_cnt_q == FL_W'(FL_LAST)) begin
                        state_d = ST_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FL_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering (or sitting in) IDLE discards the buffer and all progress.
        if (state_d == ST_IDLE) begin
            buf_full_d  = 1'b0;
            div_cnt_d   = '0;
            osr_cnt_d   = '0;
            flush_cnt_d = '0;
            stop_pend_d = 1'b0;
            dac_data_d  = '0;
        end

        ready_d    = ((state_d == ST_WAIT_FIRST) || (state_d == ST_RUN)) && !buf_full_d;
        busy_d     = (state_d != ST_IDLE);
        // A new underrun wins over a simultaneous clear.
        underrun_d = underrun_set ? 1'b1 : (i_clr_status ? 1'b0 : underrun_q);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            div_cnt_q   <= '0;
            osr_cnt_q   <= '0;
            flush_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            dac_data_q  <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            div_cnt_q   <= div_cnt_d;
            osr_cnt_q   <= osr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stop_pend_q <= stop_pend_d;
            dac_data_q  <= dac_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_s_ready     = ready_q;
    assign o_dac_en      = dac_en_c;
    assign o_dac_data    = dac_data_q;
    assign o_sample_tick = boundary_c;
    assign o_busy        = busy_q;
    assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_dsm_dac_ctrl.sv
// Directed bench for dsm_dac_ctrl (DATA_WIDTH=4, OSR=4, CLK_DIV=2,
// FLUSH_PERIODS=2). A per-cycle vector table covers start-up, a continuous
// stream, an underrun and its clear; hand-written sequences cover the
// same-cycle boundary/transfer case, stop with flush, and reset mid-run.
// Inputs change and outputs are sampled on the falling edge.
module tb_dsm_dac_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = 4'h0;
    logic       clr = 1'b0;
    logic       ready;
    logic       dac_en;
    logic [3:0] dac_data;
    logic       tick;
    logic       busy;
    logic       underrun;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DSM_DAC_CTRL_HOLD_ON_UNDERRUN_EN
    localparam logic [3:0] UR_STREAM = 4'h8; // holds -8
    localparam logic [3:0] UR_SEQ_A  = 4'h5; // holds 5
`else
    localparam logic [3:0] UR_STREAM = 4'h0;
    localparam logic [3:0] UR_SEQ_A  = 4'h0;
`endif

    dsm_dac_ctrl #(
        .DATA_WIDTH   (4),
        .OSR          (4),
        .CLK_DIV      (2),
        .FLUSH_PERIODS(2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_s_valid    (valid),
        .o_s_ready    (ready),
        .i_s_data     (data),
        .o_dac_en     (dac_en),
        .o_dac_data   (dac_data),
        .o_sample_tick(tick),
        .o_busy       (busy),
        .o_underrun   (underrun),
        .i_clr_status (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       valid;
        logic [3:0] data;
        logic       clr;
        logic       rdy;
        logic       en;
        logic [3:0] dat;
        logic       tick;
        logic       busy;
        logic       unr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_row(input logic s, input logic v, input logic [3:0] d, input logic c,
                           input logic rdy, input logic en, input logic [3:0] dat,
                           input logic tk, input logic bs, input logic ur);
        vec_t r;
        r.start = s;  r.valid = v;  r.data = d;  r.clr = c;
        r.rdy = rdy;  r.en = en;    r.dat = dat; r.tick = tk;
        r.busy = bs;  r.unr = ur;
        tbl.push_back(r);
    endtask

    // One 8-clock sample period playing dat; optionally push pd on its first cycle.
    task automatic add_period(input logic [3:0] dat, input logic push, input logic [3:0] pd);
        for (int c = 0; c < 8; c++) begin
            add_row(1'b1, push && (c == 0), (push && (c == 0)) ? pd : 4'h0, 1'b0,
                    (c == 0) ? 1'b1 : !push, (c % 2) == 1, dat, c == 7, 1'b1, 1'b0);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [3:0] d, input logic c);
        start = s;
        valid = v;
        data  = d;
        clr   = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; valid = 1'b0; data = 4'h0; clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From IDLE: request start, push d, land on the first RUN cycle.
    task automatic start_run(input logic [3:0] d);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, d,    1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        // Start, then stream 3, -2, 7, -8, then starve into an underrun and clear it.
        add_row(1, 0, 4'h0, 0,  0, 0, 4'h0, 0, 0, 0);
        add_row(1, 1, 4'h3, 0,  1, 0, 4'h0, 0, 1, 0);
        add_row(1, 0, 4'h0, 0,  0, 0, 4'h0, 0, 1, 0);
        add_period(4'h3, 1'b1, 4'hE);
        add_period(4'hE, 1'b1, 4'h7);
        add_period(4'h7, 1'b1, 4'h8);
        add_period(4'h8, 1'b0, 4'h0);
        add_row(1, 0, 4'h0, 1,  1, 0, UR_STREAM, 0, 1, 1);
        add_row(1, 0, 4'h0, 0,  1, 1, UR_STREAM, 0, 1, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("row%0d ready", i),    int'(ready),    int'(tbl[i].rdy));
            chk($sformatf("row%0d dac_en", i),   int'(dac_en),   int'(tbl[i].en));
            chk($sformatf("row%0d dac_data", i), int'(dac_data), int'(tbl[i].dat));
            chk($sformatf("row%0d tick", i),     int'(tick),     int'(tbl[i].tick));
            chk($sformatf("row%0d busy", i),     int'(busy),     int'(tbl[i].busy));
            chk($sformatf("row%0d underrun", i), int'(underrun), int'(tbl[i].unr));
            step(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].clr);
        end

        // Same-cycle boundary and transfer on an empty buffer, with clear: set wins.
        do_reset();
        start_run(4'h5);
        chk("A c0 data", int'(dac_data), 5);
        chk("A c0 en", int'(dac_en), 0);
        repeat (7) step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("A c7 tick", int'(tick), 1);
        chk("A c7 ready", int'(ready), 1);
        step(1'b1, 1'b1, 4'hC, 1'b1);
        chk("A c8 underrun", int'(underrun), 1);
        chk("A c8 data", int'(dac_data), int'(UR_SEQ_A));
        chk("A c8 ready", int'(ready), 0);
        repeat (7) step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("A c15 tick", int'(tick), 1);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("A c16 data", int'(dac_data), 12);
        chk("A c16 underrun", int'(underrun), 1);

        // Stop mid-period; the brief start re-assertion must be ignored.
        do_reset();
        start_run(4'h3);
        step(1'b1, 1'b1, 4'h6, 1'b0);
        repeat (2) step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("B c7 tick", int'(tick), 1);
        chk("B c7 data", int'(dac_data), 3);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 8; k < 24; k++) begin
            chk($sformatf("B c%0d data", k), int'(dac_data), 0);
            chk($sformatf("B c%0d en", k),   int'(dac_en), k % 2);
            chk($sformatf("B c%0d tick", k), int'(tick), int'(k == 15 || k == 23));
            chk($sformatf("B c%0d busy", k), int'(busy), 1);
            chk($sformatf("B c%0d ready", k), int'(ready), 0);
            step(1'b1, 1'b0, 4'h0, 1'b0);
        end
        chk("B c24 busy", int'(busy), 0);
        chk("B c24 en", int'(dac_en), 0);
        chk("B c24 underrun", int'(underrun), 0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("B c25 busy", int'(busy), 1);
        chk("B c25 ready", int'(ready), 1);
        chk("B c25 en", int'(dac_en), 0);

        // Asynchronous reset in RUN with a sample buffered.
        do_reset();
        start_run(4'h2);
        step(1'b1, 1'b1, 4'h1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("C c3 en", int'(dac_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("C rst data", int'(dac_data), 0);
        chk("C rst en", int'(dac_en), 0);
        chk("C rst busy", int'(busy), 0);
        chk("C rst ready", int'(ready), 0);
        chk("C rst tick", int'(tick), 0);
        chk("C rst underrun", int'(underrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("C restart busy", int'(busy), 1);
        chk("C restart ready", int'(ready), 1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 4'h0, 1'b0);
            chk($sformatf("C wait%0d en", k), int'(dac_en), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
